id_exe_pipe_reg: RTL and testbench
==================================

// Module: id_exe_pipe_reg
// PURPOSE
//  ID->EXE pipeline register of the ARM core. Latches decoded control and operands.
//  Drives src1/src2 to the EXE-stage forwarding unit and the EXE operand muxes.
//  Supports freeze (hazard stall), flush (taken branch) and valid tracking.
//  Keeps saturating stall and flush event counters for performance debug.
// PARAMETERS
//  WORD_W      32  data/PC width
//  REG_ADDR_W   4  register-file address width (src1, src2, dest)
//  CNT_W       16  width of each saturating event counter
// PORTS
//  clk            in   1           rising-edge clock
//  rst            in   1           asynchronous, active-high reset
//  freeze         in   1           hold all registered state (hazard stall)
//  flush          in   1           insert bubble (taken branch in EXE)
//  id_valid       in   1           ID stage holds a real instruction
//  id_wb_en       in   1           writeback enable
//  id_mem_r_en    in   1           load
//  id_mem_w_en    in   1           store
//  id_b           in   1           branch
//  id_s           in   1           update status
//  id_imm         in   1           immediate operand select
//  id_exe_cmd     in   4           ALU command
//  id_pc          in   WORD_W      PC+4 of instruction
//  id_val_rn      in   WORD_W      Rn value from register file
//  id_val_rm      in   WORD_W      Rm value from register file
//  id_shift_op    in   12          shifter operand
//  id_simm24      in   24          signed branch immediate
//  id_dest        in   REG_ADDR_W  destination register
//  id_src1        in   REG_ADDR_W  first source register
//  id_src2        in   REG_ADDR_W  second source register
//  id_status      in   4           NZCV at decode
//  exe_*          out  (same)      registered copies of every id_* input above
//  stall_cnt      out  CNT_W       cycles with freeze=1 and flush=0
//  flush_cnt      out  CNT_W       cycles with flush=1
// BEHAVIOUR
//  - Reset (async, immediate): all exe_* outputs = 0, both counters = 0. Reset
//    asserted mid-operation discards any held instruction.
//  - Update on posedge clk. Priority: flush > freeze > load.
//    - flush=1: all exe_* = 0. The result is a bubble with exe_valid=0 and no
//      wb/mem/b/s. flush_cnt increments. Flush wins when asserted with freeze.
//    - freeze=1, flush=0: all exe_* hold their values. stall_cnt increments.
//    - otherwise: exe_* <= id_*.
//  - Latency: 1 cycle from id_* to exe_*. Outputs are registered only; no combinational input->output path.
//  - Control gating: when loading, exe_wb_en/mem_r_en/mem_w_en/b/s = id_* AND
//    id_valid. Data fields load unmodified.
//  - exe_src1/exe_src2 always reflect the held instruction, including under freeze.
//    The forwarding unit therefore compares against stable operands.
//  - Counters saturate at 2^CNT_W-1. They never wrap. Cleared only by rst.
//  - Exactly one of {flush, freeze, load} per cycle. The counters never both
//    increment in the same cycle.
// TESTING
//  1 rst=1 then 0; no stimulus -> all exe_*=0, stall_cnt=flush_cnt=0.
//  2 id_valid=1, id_wb_en=1, id_dest=4'h3, id_val_rn=32'h1234 -> next edge:
//    exe_wb_en=1, exe_dest=3, exe_val_rn=32'h1234.
//  3 freeze=1 for 3 cycles while id_* change -> exe_* unchanged, stall_cnt=3.
//  4 flush=1 and freeze=1 in the same cycle -> exe_valid=0, exe_wb_en=0,
//    flush_cnt+1, stall_cnt unchanged.
//  5 id_valid=0 with id_mem_w_en=1, id_wb_en=1 -> exe_mem_w_en=0, exe_wb_en=0.
//  6 CNT_W=4, freeze held 20 cycles -> stall_cnt=15 and holds. Assert rst
//    mid-freeze -> counters and exe_* = 0 asynchronously.

Source files
------------

// File: rtl/id_exe_pipe_reg.sv
// rtl/id_exe_pipe_reg.sv - ID->EXE pipeline register with freeze, flush, valid gating and saturating event counters
module id_exe_pipe_reg #(
    parameter int WORD_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic                  id_wb_en,
    input  logic                  id_mem_r_en,
    input  logic                  id_mem_w_en,
    input  logic                  id_b,
    input  logic                  id_s,
    input  logic                  id_imm,
    input  logic [3:0]            id_exe_cmd,
    input  logic [WORD_W-1:0]     id_pc,
    input  logic [WORD_W-1:0]     id_val_rn,
    input  logic [WORD_W-1:0]     id_val_rm,
    input  logic [11:0]           id_shift_op,
    input  logic [23:0]           id_simm24,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic [3:0]            id_status,
    output logic                  exe_valid,
    output logic                  exe_wb_en,
    output logic                  exe_mem_r_en,
    output logic                  exe_mem_w_en,
    output logic                  exe_b,
    output logic                  exe_s,
    output logic                  exe_imm,
    output logic [3:0]            exe_exe_cmd,
    output logic [WORD_W-1:0]     exe_pc,
    output logic [WORD_W-1:0]     exe_val_rn,
    output logic [WORD_W-1:0]     exe_val_rm,
    output logic [11:0]           exe_shift_op,
    output logic [23:0]           exe_simm24,
    output logic [REG_ADDR_W-1:0] exe_dest,
    output logic [REG_ADDR_W-1:0] exe_src1,
    output logic [REG_ADDR_W-1:0] exe_src2,
    output logic [3:0]            exe_status,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int PIPE_W = 7 + 4 + 3 * WORD_W + 12 + 24 + 3 * REG_ADDR_W + 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PIPE_W-1:0] pipe_q;
    logic [PIPE_W-1:0] load_d;

    // Side-effecting controls are qualified by id_valid so a bubble from ID
    // can never write back, touch memory, branch or update flags.
    assign load_d = {id_valid,
                     id_wb_en    & id_valid,
                     id_mem_r_en & id_valid,
                     id_mem_w_en & id_valid,
                     id_b        & id_valid,
                     id_s        & id_valid,
                     id_imm, id_exe_cmd, id_pc, id_val_rn, id_val_rm,
                     id_shift_op, id_simm24, id_dest, id_src1, id_src2,
                     id_status};

    assign {exe_valid, exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_b, exe_s,
            exe_imm, exe_exe_cmd, exe_pc, exe_val_rn, exe_val_rm,
            exe_shift_op, exe_simm24, exe_dest, exe_src1, exe_src2,
            exe_status} = pipe_q;

    // Flush outranks freeze so a taken branch always kills the stalled slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q    <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (flush) begin
            pipe_q <= '0;
            if (flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end else if (freeze) begin
            if (stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end else begin
            pipe_q <= load_d;
        end
    end

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// tb/tb_id_exe_pipe_reg.sv - scoreboard bench for id_exe_pipe_reg with a random stimulus and reference model
module tb_id_exe_pipe_reg;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic        valid, wb_en, mem_r_en, mem_w_en, b, s, imm;
        logic [3:0]  cmd;
        logic [31:0] pc, rn, rm;
        logic [11:0] sh;
        logic [23:0] simm;
        logic [3:0]  dest, src1, src2, status;
    } ins_t;

    typedef struct {
        ins_t ins;
        int   stall;
        int   flsh;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic freeze = 1'b0;
    logic flush = 1'b0;
    ins_t id = '0;
    ins_t act;
    logic [CW-1:0] stall_cnt, flush_cnt;

    exp_t sb[$];
    ins_t m_ins = '0;
    int   m_stall = 0;
    int   m_flush = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    bit   mon_en = 0;
    event sample_ev;

    always #5 clk = ~clk;

    id_exe_pipe_reg #(.WORD_W(32), .REG_ADDR_W(4), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .id_valid(id.valid), .id_wb_en(id.wb_en), .id_mem_r_en(id.mem_r_en),
        .id_mem_w_en(id.mem_w_en), .id_b(id.b), .id_s(id.s), .id_imm(id.imm),
        .id_exe_cmd(id.cmd), .id_pc(id.pc), .id_val_rn(id.rn), .id_val_rm(id.rm),
        .id_shift_op(id.sh), .id_simm24(id.simm), .id_dest(id.dest),
        .id_src1(id.src1), .id_src2(id.src2), .id_status(id.status),
        .exe_valid(act.valid), .exe_wb_en(act.wb_en), .exe_mem_r_en(act.mem_r_en),
        .exe_mem_w_en(act.mem_w_en), .exe_b(act.b), .exe_s(act.s), .exe_imm(act.imm),
        .exe_exe_cmd(act.cmd), .exe_pc(act.pc), .exe_val_rn(act.rn), .exe_val_rm(act.rm),
        .exe_shift_op(act.sh), .exe_simm24(act.simm), .exe_dest(act.dest),
        .exe_src1(act.src1), .exe_src2(act.src2), .exe_status(act.status),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.ins   = m_ins;
        e.stall = m_stall;
        e.flsh  = m_flush;
        sb.push_back(e);
    endtask

    function automatic ins_t rand_id();
        logic [159:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[158:0];
    endfunction

    // Called at a negedge: drive inputs, advance the reference model, queue the post-edge expectation.
    task automatic step(input bit fl, input bit fr, input ins_t nxt);
        flush  = fl;
        freeze = fr;
        id     = nxt;
        if (fl) begin
            m_ins   = '0;
            m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
        end else if (fr) begin
            m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
        end else begin
            m_ins = nxt;
            if (!nxt.valid) begin
                m_ins.wb_en    = 1'b0;
                m_ins.mem_r_en = 1'b0;
                m_ins.mem_w_en = 1'b0;
                m_ins.b        = 1'b0;
                m_ins.s        = 1'b0;
            end
        end
        push_exp();
        @(negedge clk);
    endtask

    // Reset is raised mid-cycle and sampled 2 time units later, well before any edge.
    task automatic do_reset();
        rst     = 1'b1;
        mon_en  = 1;
        m_ins   = '0;
        m_stall = 0;
        m_flush = 0;
        push_exp();
        #2 -> sample_ev;
        push_exp();
        @(negedge clk);
        rst = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en) -> sample_ev;
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(sample_ev);
            if (sb.size() == 0) begin
                chk("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                n_vec++;
                if (act !== e.ins) begin
                    n_bad++;
                    $display("FAIL exe_fields @%0t: got %h expected %h", $time, act, e.ins);
                end
                chk("stall_cnt", 32'(stall_cnt), 32'(e.stall));
                chk("flush_cnt", 32'(flush_cnt), 32'(e.flsh));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        ins_t t;
        @(negedge clk);
        do_reset();

        t = '0;
        t.valid = 1'b1; t.wb_en = 1'b1; t.dest = 4'h3; t.rn = 32'h1234;
        step(0, 0, t);
        chk("load_wb_en", 32'(act.wb_en), 32'd1);
        chk("load_dest", 32'(act.dest), 32'd3);
        chk("load_val_rn", act.rn, 32'h1234);

        for (int i = 0; i < 3; i++) step(0, 1, rand_id());
        chk("freeze_stall_cnt", 32'(stall_cnt), 32'd3);
        chk("freeze_holds_dest", 32'(act.dest), 32'd3);

        step(1, 1, rand_id());
        chk("flush_freeze_valid", 32'(act.valid), 32'd0);
        chk("flush_freeze_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("flush_freeze_stall_cnt", 32'(stall_cnt), 32'd3);

        t = rand_id();
        t.valid = 1'b0; t.mem_w_en = 1'b1; t.wb_en = 1'b1;
        step(0, 0, t);
        chk("gated_mem_w_en", 32'(act.mem_w_en), 32'd0);
        chk("gated_wb_en", 32'(act.wb_en), 32'd0);

        t = rand_id();
        t.valid = 1'b1;
        step(0, 0, t);
        for (int i = 0; i < 20; i++) step(0, 1, rand_id());
        chk("stall_saturated", 32'(stall_cnt), CMAX);
        do_reset();
        chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("reset_valid", 32'(act.valid), 32'd0);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, rand_id());
            end
        end
        freeze = 1'b0;
        flush  = 1'b0;
        mon_en = 0;
        @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
